// File: rtl/libmm_sched_pkg.sv
// rtl/libmm_sched_pkg.sv - shared widths, FSM states, init command and error bit indices for libmm_req_sched
package libmm_sched_pkg;

  localparam int LIBMM_REQ_W  = 72;
  localparam int LIBMM_RESP_W = 48;
  localparam int LIBMM_CTRL_W = 40;

  localparam logic [LIBMM_CTRL_W-1:0] LIBMM_INIT_CMD = 40'h0;

  localparam int ERR_INIT      = 0;
  localparam int ERR_RD_ORPHAN = 1;
  localparam int ERR_WR_ORPHAN = 2;

  typedef enum logic [1:0] {
    INIT_REQ  = 2'd0,
    INIT_WAIT = 2'd1,
    RUN       = 2'd2,
    FAIL      = 2'd3
  } sched_state_e;

endpackage

// File: rtl/libmm_tag_fifo.sv
// rtl/libmm_tag_fifo.sv - in-order FIFO of requester IDs for one request channel
module libmm_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [W-1:0]           push_id_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_id_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign head_id_o = mem_q[rd_ptr_q];
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/libmm_req_sched.sv
// rtl/libmm_req_sched.sv - init sequencer, round-robin request arbiter and in-order response router for libmm
// Optional statistics counters are built when LIBMM_SCHED_STATS_EN is defined.
module libmm_req_sched
  import libmm_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int OUTSTANDING = 8,
  parameter int REQ_W       = libmm_sched_pkg::LIBMM_REQ_W,
  parameter int RESP_W      = libmm_sched_pkg::LIBMM_RESP_W,
  parameter int CTRL_W      = libmm_sched_pkg::LIBMM_CTRL_W
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NUM_REQ*REQ_W-1:0] req_rd_tdata,
  input  logic [NUM_REQ-1:0]       req_rd_tvalid,
  output logic [NUM_REQ-1:0]       req_rd_tready,
  input  logic [NUM_REQ*REQ_W-1:0] req_wr_tdata,
  input  logic [NUM_REQ-1:0]       req_wr_tvalid,
  output logic [NUM_REQ-1:0]       req_wr_tready,
  output logic [RESP_W-1:0]        resp_rd_tdata,
  output logic [NUM_REQ-1:0]       resp_rd_tvalid,
  input  logic [NUM_REQ-1:0]       resp_rd_tready,
  output logic [RESP_W-1:0]        resp_wr_tdata,
  output logic [NUM_REQ-1:0]       resp_wr_tvalid,
  input  logic [NUM_REQ-1:0]       resp_wr_tready,
  output logic [REQ_W-1:0]         in_read_tdata,
  output logic                     in_read_tvalid,
  input  logic                     in_read_tready,
  output logic [REQ_W-1:0]         in_write_tdata,
  output logic                     in_write_tvalid,
  input  logic                     in_write_tready,
  input  logic [RESP_W-1:0]        out_read_tdata,
  input  logic                     out_read_tvalid,
  output logic                     out_read_tready,
  input  logic [RESP_W-1:0]        out_write_tdata,
  input  logic                     out_write_tvalid,
  output logic                     out_write_tready,
  output logic [CTRL_W-1:0]        ctrl_in_tdata,
  output logic                     ctrl_in_tvalid,
  input  logic                     ctrl_in_tready,
  input  logic [CTRL_W-1:0]        ctrl_out_tdata,
  input  logic                     ctrl_out_tvalid,
  output logic                     ctrl_out_tready,
  output logic                     sched_run,
  output logic [2:0]               sched_err,
  output logic [31:0]              stat_rd_cnt,
  output logic [31:0]              stat_wr_cnt,
  output logic [31:0]              stat_stall_cnt
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING) + 1;

  sched_state_e state_q, state_d;
  logic [2:0]   err_q, err_d;
  logic         alive_q, run;

  // Channel 0 is read, channel 1 is write; both share one arbiter/router body.
  logic [NUM_REQ-1:0]       ch_req_v [2], ch_req_rdy [2], ch_resp_v [2], ch_resp_rdy [2];
  logic [NUM_REQ*REQ_W-1:0] ch_req_data [2];
  logic [REQ_W-1:0]         ch_in_data [2];
  logic [RESP_W-1:0]        ch_out_data [2], ch_resp_data [2];
  logic [CNT_W-1:0]         ch_count [2];
  logic [1:0]               ch_in_v, ch_in_rdy, ch_out_v, ch_out_rdy, ch_hs, ch_orphan;

  assign ch_req_v[0]    = req_rd_tvalid;
  assign ch_req_v[1]    = req_wr_tvalid;
  assign ch_req_data[0] = req_rd_tdata;
  assign ch_req_data[1] = req_wr_tdata;
  assign ch_resp_rdy[0] = resp_rd_tready;
  assign ch_resp_rdy[1] = resp_wr_tready;
  assign ch_in_rdy      = {in_write_tready, in_read_tready};
  assign ch_out_v       = {out_write_tvalid, out_read_tvalid};
  assign ch_out_data[0] = out_read_tdata;
  assign ch_out_data[1] = out_write_tdata;

  assign req_rd_tready    = ch_req_rdy[0];
  assign req_wr_tready    = ch_req_rdy[1];
  assign resp_rd_tvalid   = ch_resp_v[0];
  assign resp_wr_tvalid   = ch_resp_v[1];
  assign resp_rd_tdata    = ch_resp_data[0];
  assign resp_wr_tdata    = ch_resp_data[1];
  assign in_read_tdata    = ch_in_data[0];
  assign in_write_tdata   = ch_in_data[1];
  assign in_read_tvalid   = ch_in_v[0];
  assign in_write_tvalid  = ch_in_v[1];
  assign out_read_tready  = ch_out_rdy[0];
  assign out_write_tready = ch_out_rdy[1];

  assign run             = (state_q == RUN);
  assign sched_run       = run;
  assign sched_err       = err_q;
  assign ctrl_in_tvalid  = alive_q & (state_q == INIT_REQ);
  assign ctrl_in_tdata   = ctrl_in_tvalid ? LIBMM_INIT_CMD : '0;
  assign ctrl_out_tready = alive_q & ((state_q == INIT_WAIT) || run);

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [ID_W-1:0] rr_q, lock_id_q, rr_pick, pick, head;
    logic            lock_q, full, empty, grant, pop;

    // Reverse scan so the last hit is the first valid requester after rr_q.
    always_comb begin
      rr_pick = rr_q;
      for (int k = NUM_REQ; k >= 1; k--) begin
        if (ch_req_v[c][(int'(rr_q) + k) % NUM_REQ]) rr_pick = ID_W'((int'(rr_q) + k) % NUM_REQ);
      end
    end

    assign pick            = lock_q ? lock_id_q : rr_pick;
    assign grant           = run & ~full & ch_req_v[c][pick];
    assign ch_in_v[c]      = grant;
    assign ch_in_data[c]   = grant ? ch_req_data[c][int'(pick)*REQ_W +: REQ_W] : '0;
    assign ch_req_rdy[c]   = (run & ~full & ch_in_rdy[c]) ? (NUM_REQ'(1) << pick) : '0;
    assign ch_hs[c]        = grant & ch_in_rdy[c];
    assign ch_resp_v[c]    = empty ? '0 : (NUM_REQ'(ch_out_v[c]) << head);
    assign ch_resp_data[c] = empty ? '0 : ch_out_data[c];
    assign ch_out_rdy[c]   = empty ? alive_q : ch_resp_rdy[c][head];
    assign pop             = ~empty & ch_out_v[c] & ch_resp_rdy[c][head];
    assign ch_orphan[c]    = alive_q & empty & ch_out_v[c];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        rr_q      <= '0;
        lock_q    <= 1'b0;
        lock_id_q <= '0;
      end else begin
        lock_q    <= grant & ~ch_in_rdy[c];
        lock_id_q <= pick;
        if (ch_hs[c]) rr_q <= pick;
      end
    end

    libmm_tag_fifo #(.DEPTH(OUTSTANDING), .W(ID_W)) u_fifo (
      .clk       (sys_clk),
      .rst       (sys_rst),
      .push_i    (ch_hs[c]),
      .push_id_i (pick),
      .pop_i     (pop),
      .head_id_o (head),
      .full_o    (full),
      .empty_o   (empty),
      .count_o   (ch_count[c])
    );
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      INIT_REQ:  if (ctrl_in_tvalid && ctrl_in_tready) state_d = INIT_WAIT;
      INIT_WAIT: if (ctrl_out_tvalid) begin
        state_d = (ctrl_out_tdata[7:0] == 8'h0) ? RUN : FAIL;
        err_d[ERR_INIT] = err_q[ERR_INIT] | (ctrl_out_tdata[7:0] != 8'h0);
      end
      default: state_d = state_q;
    endcase
    err_d[ERR_RD_ORPHAN] = err_q[ERR_RD_ORPHAN] | ch_orphan[0];
    err_d[ERR_WR_ORPHAN] = err_q[ERR_WR_ORPHAN] | ch_orphan[1];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= INIT_REQ;
      err_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      alive_q <= 1'b1;
    end
  end

`ifdef LIBMM_SCHED_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (ch_hs[0]) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (ch_hs[1]) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (run && (|req_rd_tvalid || |req_wr_tvalid) && ch_hs == 2'b00) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_rd_cnt    = rd_cnt_q;
  assign stat_wr_cnt    = wr_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  assign stat_rd_cnt    = '0;
  assign stat_wr_cnt    = '0;
  assign stat_stall_cnt = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{ctrl_out_tdata[CTRL_W-1:8], ch_count[0], ch_count[1]};

endmodule

// File: doc/libmm_req_sched.md
Name: libmm_req_sched

Overview:
- Front-end sequencer and arbiter for the libmm paging IP.
- After reset it issues the init command on ctrl_in and waits for ctrl_out success before any traffic.
- In RUN it round-robins NUM_REQ requesters onto the single in_read/in_write request channels.
- Responses on out_read/out_write return to the issuing requester, using per-channel in-order tag FIFOs.

Parameters:
- NUM_REQ, 2: requester count (2..8).
- OUTSTANDING, 8: max in-flight requests per channel (tag FIFO depth, power of 2).
- REQ_W, 72: request tdata width.
- RESP_W, 48: response tdata width.
- CTRL_W, 40: control tdata width.

Ports:
- sys_clk  in  1  sole clock.
- sys_rst  in  1  asynchronous active-high reset.
- req_rd_tdata/tvalid/tready  in/in/out  NUM_REQ*REQ_W / NUM_REQ / NUM_REQ  per-requester read requests; requester i uses slice i.
- req_wr_tdata/tvalid/tready  in/in/out  NUM_REQ*REQ_W / NUM_REQ / NUM_REQ  per-requester write requests.
- resp_rd_tdata/tvalid/tready  out/out/in  RESP_W / NUM_REQ / NUM_REQ  read responses; tdata shared, tvalid one-hot.
- resp_wr_tdata/tvalid/tready  out/out/in  RESP_W / NUM_REQ / NUM_REQ  write responses; tdata shared, tvalid one-hot.
- in_read_tdata/tvalid/tready  out/out/in  REQ_W/1/1  to paging IP.
- in_write_tdata/tvalid/tready  out/out/in  REQ_W/1/1  to paging IP.
- out_read_tdata/tvalid/tready  in/in/out  RESP_W/1/1  from paging IP.
- out_write_tdata/tvalid/tready  in/in/out  RESP_W/1/1  from paging IP.
- ctrl_in_tdata/tvalid/tready  out/out/in  CTRL_W/1/1  command to paging IP.
- ctrl_out_tdata/tvalid/tready  in/in/out  CTRL_W/1/1  status from paging IP.
- sched_run  out  1  high in RUN.
- sched_err  out  3  sticky errors: [0] init fail, [1] read orphan response, [2] write orphan response.
- stat_rd_cnt, stat_wr_cnt, stat_stall_cnt  out  32 each  statistics (see Optional Feature).

Behaviour:
- Reset: all outputs are 0, FSM is in INIT_REQ, FIFOs are empty, RR pointers are 0, sched_err is 0.
- Reset is asynchronous at any time, including mid-burst. In-flight tags are discarded; the paging IP is reset alongside on the same sys_rst.
- FSM INIT_REQ: ctrl_in_tvalid=1, ctrl_in_tdata=40'h0, held stable until ctrl_in_tready; then go to INIT_WAIT.
- FSM INIT_WAIT: ctrl_out_tready=1. On ctrl_out_tvalid: tdata[7:0]==0 goes to RUN; otherwise go to FAIL and set sched_err[0].
- FSM RUN: ctrl_out_tready=1; extra ctrl_out beats are consumed and ignored.
- FSM FAIL: terminal until reset.
- Outside RUN, all req_*_tready=0 and in_read/in_write tvalid=0.
- Arbitration: read and write channels arbitrate independently, zero-cycle pass-through.
  - pick = first valid requester at or after rr_ptr+1 (mod NUM_REQ).
  - When out tvalid=1 and tready=0, pick is locked in a register until the handshake; tdata stays stable (AXIS rule).
  - On handshake: rr_ptr<=pick, and pick ID is pushed into that channel's tag FIFO in the same cycle.
  - req_x_tready[i] = (pick==i) & in_x_tready & run & !fifo_full.
- Tag FIFO full: the grant is withheld (tvalid=0) even if a pop occurs in the same cycle. Full means count==OUTSTANDING.
- Response routing:
  - Head tag h selects resp_x_tvalid[h]=out_x_tvalid; out_x_tready=resp_x_tready[h]; pop on handshake.
  - Response path is combinational.
  - Simultaneous push and pop on a non-full FIFO: count unchanged.
- Orphan response (out_x_tvalid while FIFO empty): out_x_tready=1, the beat is dropped, sched_err[1]/[2] is set.
- No reordering: the paging IP returns responses in order per channel.

Optional Feature:
- Macro LIBMM_SCHED_STATS_EN.
- Defined: stat_rd_cnt/stat_wr_cnt count request handshakes on in_read/in_write. stat_stall_cnt counts cycles where any requester is valid in RUN but no request handshake occurs on either channel. All are 32-bit and wrap, and clear on reset.
- Undefined: all three stat ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Package libmm_sched_pkg: width constants (REQ_W, RESP_W, CTRL_W), FSM state enum (INIT_REQ, INIT_WAIT, RUN, FAIL), LIBMM_INIT_CMD=40'h0, err bit indices.
- Sub-module libmm_tag_fifo: synchronous FIFO of $clog2(NUM_REQ)-bit IDs with full/empty/count. Instantiated once per channel.

Test Plan:
- Reset, then ctrl_in_tready after 3 cycles, then ctrl_out 40'h0 -> exactly one ctrl_in beat of 40'h0; sched_run=1 the cycle after the ctrl_out handshake.
- ctrl_out reply 40'h01 -> sched_err=3'b001, sched_run stays 0, all req tready stay 0 under requests.
- Both requesters stream 4 reads continuously with in_read_tready=1 -> in_read order is R1,R0,R1,R0,...; 4 responses route to resp_rd_tvalid 2'b10,2'b01,2'b10,2'b01.
- OUTSTANDING=8, hold out_read_tvalid=0 -> 8 grants, then in_read_tvalid=0; one response pops and the next grant follows the cycle after.
- out_write_tvalid with no write outstanding, data 48'hABC -> beat consumed, sched_err[2]=1, no resp_wr_tvalid.
- Assert sys_rst mid-burst with 3 reads in flight -> outputs are 0 immediately; after release the FSM re-issues the init command and FIFO count=0.
